tm_controller: RTL and testbench
================================

# tm_controller

Finite-state control unit for the Turing machine: the consumer end of the tape read/write/move protocol. Each time the tape presents a valid symbol, it looks up a programmable transition table indexed by {current state, symbol}. It returns the symbol to write and the head direction, then advances the machine state. It also tracks run/halt status and counts executed steps for the host.

## Interface

**Parameters**
- STATE_W, 4: width of machine state; table depth is 2^(STATE_W+3).
- START_STATE, 0: state loaded on run.
- HALT_STATE, 2^STATE_W-1: entering this state halts the machine.

**Ports**
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- prog_we  in  1  table write strobe.
- prog_addr  in  STATE_W+3  table index {state, sym}.
- prog_data  in  STATE_W+4  entry {next_state[STATE_W-1:0], wr_sym[2:0], dir}; dir=1 means right (+1).
- run  in  1  one-cycle start pulse.
- sym  in  3  symbol under the head.
- sym_valid  in  1  sym is valid this cycle (tape read phase).
- new_sym  out  3  symbol for the tape write phase (registered).
- direction  out  1  head move for the tape move phase (registered).
- busy  out  1  machine in RUN.
- halted  out  1  machine in HALTED.
- state  out  STATE_W  current machine state.
- step_count  out  32  transitions executed since last run.

## Operation

**Modes**
- IDLE, RUN and HALTED.
- busy = (mode == RUN); halted = (mode == HALTED).

**Reset values** (applied immediately, no clock needed)
- mode = IDLE, state = START_STATE, new_sym = 0, direction = 0, park toggle = 0, step_count = 0.
- Table contents are not reset; they are undefined until programmed.

**Programming**
- On a clock edge with prog_we=1 and mode ≠ RUN: table[prog_addr] <= prog_data.
- prog_we is ignored while mode = RUN.

**run pulse**
- Honoured in any mode, including RUN, where it acts as a restart.
- Effect: state <= START_STATE, step_count <= 0, mode <= RUN.
- If START_STATE == HALT_STATE, mode <= HALTED instead, with step_count = 0.

**Step** (on a sym_valid=1 edge while mode = RUN and run=0)
- entry = table[{state, sym}] (combinational read).
- new_sym <= wr_sym, direction <= dir, state <= next_state.
- step_count <= step_count+1, saturating at 0xFFFFFFFF.
- If next_state == HALT_STATE, mode <= HALTED on the same edge; the halting step is counted.

**Park** (sym_valid=1 edge and the machine does not step: IDLE, HALTED, or the run pulse coincides)
- new_sym <= sym, so the tape writes back the unchanged symbol.
- direction <= park toggle; the toggle then flips.
- The tape moves unconditionally every period. Alternating 0/1 keeps the head within ±1 of its parked cell and never alters tape content.

**Simultaneous events**
- run with sym_valid: run wins and that period parks; the first step is the next sym_valid.
- prog_we with run (mode ≠ RUN): the write completes and the run starts. The write is visible to the first lookup.
- sym_valid with no run in IDLE: park.

## Timing

- The tape asserts sym_valid one cycle in three: read, write, move.
- new_sym and direction update on the edge closing the sym_valid cycle. Both are stable through the following write and move cycles, and change only on sym_valid edges.
- Lookup latency: 0 cycles (combinational table read). Output latency: 1 edge after sym_valid.
- state, step_count and halted are valid from the cycle after the step edge.
- sym is sampled only when sym_valid=1; at other times it is don't-care.
- Asserting reset mid-run aborts immediately: outputs return to reset values asynchronously, and no partial step is retained.

## Test plan

1. **Reset values:** Assert reset asynchronously between edges mid-run → busy=0, halted=0, state=0, new_sym=0, direction=0, step_count=0 immediately, with no clock edge required.
2. **Writer loop:** Program {0,0}→{0,1,1} and {0,1}→{0,1,1}, run, supply 4 sym_valid periods with sym=0 → each period new_sym=1 and direction=1; afterwards step_count=4, state=0, busy=1.
3. **Halt then park:** Program {0,0}→{15,2,1}, run, sym=0 → halted=1, step_count=1, new_sym=2. On three later periods with sym=5 → new_sym=5 each time, direction 0,1,0, step_count remains 1.
4. **Write lock:** With entry {0,0}→{0,1,1}, assert prog_we to {0,0}={15,3,0} while busy=1, supply sym=0 → next step still yields new_sym=1, direction=1, state=0.
5. **run collides with sym_valid:** Assert run on a sym_valid cycle → that period parks (new_sym=sym) and step_count stays 0. The next sym_valid performs step 1.
6. **Restart and saturation:** Pulse run mid-RUN → step_count=0 and state=START_STATE on the next cycle. Separately, force step_count to 0xFFFFFFFF and execute one step → the counter holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/tm_controller.sv
// Turing machine control unit: consumes tape symbols, looks up a programmable
// transition table, returns write symbol and head direction, and tracks
// run/halt status plus an executed-step counter.
module tm_controller #(
  parameter int unsigned        STATE_W     = 4,
  parameter logic [STATE_W-1:0] START_STATE = '0,
  parameter logic [STATE_W-1:0] HALT_STATE  = '1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [STATE_W+2:0]   prog_addr,
  input  logic [STATE_W+3:0]   prog_data,
  input  logic                 run,
  input  logic [2:0]           sym,
  input  logic                 sym_valid,
  output logic [2:0]           new_sym,
  output logic                 direction,
  output logic                 busy,
  output logic                 halted,
  output logic [STATE_W-1:0]   state,
  output logic [31:0]          step_count
);

  localparam int unsigned ADDR_W = STATE_W + 3;
  localparam int unsigned DATA_W = STATE_W + 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_HALTED  = 2'd2
  } mode_t;

  mode_t               mode;
  logic                park_dir;
  logic [DATA_W-1:0]   tbl [DEPTH];

  logic [ADDR_W-1:0]   lookup_addr_c;
  logic [DATA_W-1:0]   entry_c;
  logic [STATE_W-1:0]  next_state_c;
  logic [2:0]          wr_sym_c;
  logic                dir_c;
  logic                step_c;

  // Transition table; writes are locked out while the machine runs.
  always_ff @(posedge clock) begin
    if (prog_we && (mode != MODE_RUN)) begin
      tbl[prog_addr] <= prog_data;
    end
  end

  // Combinational table lookup for the current {state, sym}.
  always_comb begin
    lookup_addr_c = {state, sym};
    entry_c       = tbl[lookup_addr_c];
    next_state_c  = entry_c[DATA_W-1:4];
    wr_sym_c      = entry_c[3:1];
    dir_c         = entry_c[0];
    step_c        = sym_valid && (mode == MODE_RUN) && !run;
  end

  // Mode, machine state, tape outputs and step counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode       <= MODE_IDLE;
      state      <= START_STATE;
      new_sym    <= 3'd0;
      direction  <= 1'b0;
      park_dir   <= 1'b0;
      step_count <= 32'd0;
    end else begin
      if (run) begin
        // Start or restart; a start state equal to the halt state halts at once.
        state      <= START_STATE;
        step_count <= 32'd0;
        mode       <= (START_STATE == HALT_STATE) ? MODE_HALTED : MODE_RUN;
      end else if (step_c) begin
        state <= next_state_c;
        if (step_count != 32'hFFFF_FFFF) begin
          step_count <= step_count + 32'd1;
        end
        if (next_state_c == HALT_STATE) begin
          mode <= MODE_HALTED;
        end
      end

      if (step_c) begin
        new_sym   <= wr_sym_c;
        direction <= dir_c;
      end else if (sym_valid) begin
        // Park: write back the same symbol and wiggle the head around its cell.
        new_sym   <= sym;
        direction <= park_dir;
        park_dir  <= ~park_dir;
      end
    end
  end

  assign busy   = (mode == MODE_RUN);
  assign halted = (mode == MODE_HALTED);

endmodule

// File: tb/tb_tm_controller.sv
// Directed bench for tm_controller: a vector table for a multi-state program
// plus hand-written sequences for reset, locking, collisions and saturation.
module tb_tm_controller;

  logic        clock;
  logic        reset;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [7:0]  prog_data;
  logic        run;
  logic [2:0]  sym;
  logic        sym_valid;
  logic [2:0]  new_sym;
  logic        direction;
  logic        busy;
  logic        halted;
  logic [3:0]  state;
  logic [31:0] step_count;

  int checks;
  int failures;

  tm_controller dut (
    .clock      (clock),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .run        (run),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .new_sym    (new_sym),
    .direction  (direction),
    .busy       (busy),
    .halted     (halted),
    .state      (state),
    .step_count (step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sym;
    logic [2:0]  exp_sym;
    logic        exp_dir;
    logic [3:0]  exp_state;
    logic        exp_busy;
    logic        exp_halted;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] e_sym, input logic e_dir,
                           input logic [3:0] e_state, input logic e_busy, input logic e_halted,
                           input logic [31:0] e_count);
    check({name, ".new_sym"}, 32'(new_sym), 32'(e_sym));
    check({name, ".direction"}, 32'(direction), 32'(e_dir));
    check({name, ".state"}, 32'(state), 32'(e_state));
    check({name, ".busy"}, 32'(busy), 32'(e_busy));
    check({name, ".halted"}, 32'(halted), 32'(e_halted));
    check({name, ".step_count"}, step_count, e_count);
  endtask

  function automatic logic [7:0] entry(input logic [3:0] ns, input logic [2:0] ws, input logic d);
    return {ns, ws, d};
  endfunction

  task automatic program_entry(input logic [3:0] st, input logic [2:0] sy, input logic [7:0] data);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = {st, sy};
    prog_data = data;
    @(negedge clock);
    prog_we   = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
  endtask

  // One tape period: read cycle with sym_valid, returns right after the
  // closing edge so outputs can be sampled; then two idle cycles follow.
  task automatic tape_read(input logic [2:0] s);
    @(negedge clock);
    sym_valid = 1'b1;
    sym       = s;
    @(negedge clock);
    sym_valid = 1'b0;
    sym       = 3'd0;
  endtask

  task automatic tape_idle();
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    run       = 1'b0;
    sym       = 3'd0;
    sym_valid = 1'b0;

    // Program walk: 0 -s0-> 1 -s1-> 2 -s0-> 0 -s2-> 15 (halt), then parks.
    vecs[0] = '{3'd0, 3'd3, 1'b1, 4'd1,  1'b1, 1'b0, 32'd1};
    vecs[1] = '{3'd1, 3'd4, 1'b0, 4'd2,  1'b1, 1'b0, 32'd2};
    vecs[2] = '{3'd0, 3'd5, 1'b1, 4'd0,  1'b1, 1'b0, 32'd3};
    vecs[3] = '{3'd2, 3'd6, 1'b0, 4'd15, 1'b0, 1'b1, 32'd4};
    vecs[4] = '{3'd7, 3'd7, 1'b0, 4'd15, 1'b0, 1'b1, 32'd4};
    vecs[5] = '{3'd1, 3'd1, 1'b1, 4'd15, 1'b0, 1'b1, 32'd4};
    vecs[6] = '{3'd3, 3'd3, 1'b0, 4'd15, 1'b0, 1'b1, 32'd4};

    repeat (2) @(negedge clock);
    check_all("reset_init", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    // Table-driven program run.
    program_entry(4'd0, 3'd0, entry(4'd1, 3'd3, 1'b1));
    program_entry(4'd1, 3'd1, entry(4'd2, 3'd4, 1'b0));
    program_entry(4'd2, 3'd0, entry(4'd0, 3'd5, 1'b1));
    program_entry(4'd0, 3'd2, entry(4'd15, 3'd6, 1'b0));
    pulse_run();
    check_all("vec_run", 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      tape_read(vecs[i].sym);
      check_all($sformatf("vec%0d", i), vecs[i].exp_sym, vecs[i].exp_dir, vecs[i].exp_state,
                vecs[i].exp_busy, vecs[i].exp_halted, vecs[i].exp_count);
      tape_idle();
    end

    // Park in IDLE after reset: echoes symbol, toggle starts at 0.
    do_reset();
    tape_read(3'd6);
    check_all("idle_park", 3'd6, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
    tape_idle();

    // Writer loop.
    do_reset();
    program_entry(4'd0, 3'd0, entry(4'd0, 3'd1, 1'b1));
    program_entry(4'd0, 3'd1, entry(4'd0, 3'd1, 1'b1));
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      tape_read(3'd0);
      check("writer.new_sym", 32'(new_sym), 32'd1);
      check("writer.direction", 32'(direction), 32'd1);
      tape_idle();
    end
    check_all("writer_end", 3'd1, 1'b1, 4'd0, 1'b1, 1'b0, 32'd4);

    // Asynchronous reset mid-run, between edges.
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_all("async_reset", 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Halt then park.
    program_entry(4'd0, 3'd0, entry(4'd15, 3'd2, 1'b1));
    pulse_run();
    tape_read(3'd0);
    check_all("halt", 3'd2, 1'b1, 4'd15, 1'b0, 1'b1, 32'd1);
    tape_idle();
    for (int i = 0; i < 3; i++) begin
      tape_read(3'd5);
      check_all($sformatf("park%0d", i), 3'd5, 1'(i % 2), 4'd15, 1'b0, 1'b1, 32'd1);
      tape_idle();
    end

    // Write lock while busy.
    do_reset();
    program_entry(4'd0, 3'd0, entry(4'd0, 3'd1, 1'b1));
    pulse_run();
    program_entry(4'd0, 3'd0, entry(4'd15, 3'd3, 1'b0));
    tape_read(3'd0);
    check_all("write_lock", 3'd1, 1'b1, 4'd0, 1'b1, 1'b0, 32'd1);
    tape_idle();

    // Run collides with sym_valid: park that period, step on the next.
    do_reset();
    @(negedge clock);
    run       = 1'b1;
    sym_valid = 1'b1;
    sym       = 3'd5;
    @(negedge clock);
    run       = 1'b0;
    sym_valid = 1'b0;
    check_all("collide_park", 3'd5, 1'b0, 4'd0, 1'b1, 1'b0, 32'd0);
    tape_idle();
    tape_read(3'd0);
    check_all("collide_step", 3'd1, 1'b1, 4'd0, 1'b1, 1'b0, 32'd1);
    tape_idle();

    // Program write coinciding with run is visible to the first lookup.
    do_reset();
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = {4'd0, 3'd4};
    prog_data = entry(4'd9, 3'd7, 1'b0);
    run       = 1'b1;
    @(negedge clock);
    prog_we   = 1'b0;
    run       = 1'b0;
    tape_read(3'd4);
    check_all("prog_with_run", 3'd7, 1'b0, 4'd9, 1'b1, 1'b0, 32'd1);
    tape_idle();

    // Restart mid-run.
    do_reset();
    program_entry(4'd0, 3'd0, entry(4'd1, 3'd1, 1'b1));
    program_entry(4'd1, 3'd0, entry(4'd1, 3'd1, 1'b1));
    pulse_run();
    tape_read(3'd0);
    tape_idle();
    tape_read(3'd0);
    check_all("pre_restart", 3'd1, 1'b1, 4'd1, 1'b1, 1'b0, 32'd2);
    tape_idle();
    pulse_run();
    check_all("restart", 3'd1, 1'b1, 4'd0, 1'b1, 1'b0, 32'd0);

    // Saturation at all-ones.
    @(negedge clock);
    force dut.step_count = 32'hFFFF_FFFF;
    #1 release dut.step_count;
    tape_read(3'd0);
    check_all("saturate", 3'd1, 1'b1, 4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tape_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
